multiplier_arbiter: RTL and testbench

//  Shares one combinational signed limb multiplier (NUM_ELEMENTS limbs x NUM_ELEMENTS limbs -> 2*NUM_ELEMENTS+1 limbs)

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/multiplier_arbiter.sv | 128 ++++++++++++
 tb/tb_multiplier_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared sizing and types for the limb multiplier arbiter.
// Operands are NUM_ELEMENTS signed limbs and the product is RES_LIMBS signed limbs.
package multiplier_pkg;
   localparam int NUM_ELEMENTS = 17;
   localparam int BIT_LEN      = 17;
   localparam int RES_LIMBS    = 2*NUM_ELEMENTS+1;

   typedef logic signed [BIT_LEN:0] limb_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: grants the first request at or after ptr, wrapping.
// Purely combinational; en=0 suppresses every grant.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id
);

   always_comb begin
      logic found;
      int   idx;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one external combinational limb multiplier between NUM_REQ requesters, result tagged with requester id.
// Accept-to-resp_valid latency is MUL_CYCLES+1; define MULT_ARB_B2B_EN to grant during the response handshake.
module multiplier_arbiter
   import multiplier_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MUL_CYCLES = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic  [NUM_REQ-1:0]                   req_valid,
   output logic  [NUM_REQ-1:0]                   req_ready,
   input  limb_t [NUM_REQ-1:0][NUM_ELEMENTS-1:0] req_a,
   input  limb_t [NUM_REQ-1:0][NUM_ELEMENTS-1:0] req_b,
   output limb_t [NUM_ELEMENTS-1:0]              mul_a,
   output limb_t [NUM_ELEMENTS-1:0]              mul_b,
   input  limb_t [RES_LIMBS-1:0]                 mul_c,
   output logic                                  resp_valid,
   input  logic                                  resp_ready,
   output logic  [$clog2(NUM_REQ)-1:0]           resp_id,
   output limb_t [RES_LIMBS-1:0]                 resp_c,
   output logic                                  busy
);

   localparam int IDW   = $clog2(NUM_REQ);
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;

   logic [1:0]                   state_q, state_d;
   logic [IDW-1:0]               ptr_q, ptr_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [IDW-1:0]               id_q, id_d;
   limb_t [NUM_ELEMENTS-1:0]     mul_a_q, mul_a_d;
   limb_t [NUM_ELEMENTS-1:0]     mul_b_q, mul_b_d;
   limb_t [RES_LIMBS-1:0]        resp_c_q, resp_c_d;

   logic                         arb_en;
   logic                         accept;
   logic [NUM_REQ-1:0]           gnt;
   logic [IDW-1:0]               gnt_id;

`ifdef MULT_ARB_B2B_EN
   // The response handshake cycle doubles as the next accept cycle.
   assign arb_en = (state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready);
`else
   assign arb_en = (state_q == S_IDLE);
`endif

   rr_arbiter #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_rr (
      .req    (req_valid),
      .ptr    (ptr_q),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign accept = |gnt;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      resp_c_d = resp_c_q;

      case (state_q)
         S_WAIT: begin
            // Multiplier inputs have been stable for MUL_CYCLES cycles once the count hits zero.
            if (cnt_q == '0) begin
               resp_c_d = mul_c;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         mul_a_d = req_a[gnt_id];
         mul_b_d = req_b[gnt_id];
         id_d    = gnt_id;
         cnt_d   = CNT_W'(MUL_CYCLES - 1);
         ptr_d   = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
         state_d = S_WAIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         id_q     <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         resp_c_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         resp_c_q <= resp_c_d;
      end
   end

   assign req_ready  = gnt;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_id    = id_q;
   assign resp_c     = resp_c_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: a stand-in multiplier drives mul_c and only settles after MUL_CYCLES stable cycles.
// Expected results are queued when requests are driven and popped at each response handshake.
`timescale 1ns/1ps
module tb_multiplier_arbiter;
   import multiplier_pkg::*;

   localparam int NUM_REQ    = 4;
   localparam int MUL_CYCLES = 2;
   localparam int IDW        = $clog2(NUM_REQ);
`ifdef MULT_ARB_B2B_EN
   localparam int JOB_GAP      = MUL_CYCLES + 1;
   localparam int NEXT_ACC_OFS = 0;
`else
   localparam int JOB_GAP      = MUL_CYCLES + 2;
   localparam int NEXT_ACC_OFS = 1;
`endif

   typedef limb_t [NUM_ELEMENTS-1:0] op_t;
   typedef limb_t [RES_LIMBS-1:0]    res_t;
   typedef struct {
      logic [IDW-1:0] id;
      res_t           c;
   } exp_t;

   logic                                  clk;
   logic                                  rst_n;
   logic  [NUM_REQ-1:0]                   req_valid;
   logic  [NUM_REQ-1:0]                   req_ready;
   limb_t [NUM_REQ-1:0][NUM_ELEMENTS-1:0] req_a;
   limb_t [NUM_REQ-1:0][NUM_ELEMENTS-1:0] req_b;
   op_t                                   mul_a;
   op_t                                   mul_b;
   res_t                                  mul_c;
   logic                                  resp_valid;
   logic                                  resp_ready;
   logic  [IDW-1:0]                       resp_id;
   res_t                                  resp_c;
   logic                                  busy;

   int   checks = 0;
   int   passed = 0;
   int   cyc    = 0;
   exp_t sb[$];

   multiplier_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .MUL_CYCLES (MUL_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_c      (mul_c),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_c     (resp_c),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t conv(op_t a, op_t b);
      int   acc [RES_LIMBS];
      res_t r;
      for (int k = 0; k < RES_LIMBS; k++) acc[k] = 0;
      for (int i = 0; i < NUM_ELEMENTS; i++)
         for (int j = 0; j < NUM_ELEMENTS; j++)
            acc[i+j] += int'(a[i]) * int'(b[j]);
      for (int k = 0; k < RES_LIMBS; k++) r[k] = acc[k][BIT_LEN:0];
      return r;
   endfunction

   function automatic op_t fill(int v);
      op_t o;
      for (int i = 0; i < NUM_ELEMENTS; i++) o[i] = v[BIT_LEN:0];
      return o;
   endfunction

   // Stand-in multiplier: output is corrupted until operands have been stable for MUL_CYCLES samples.
   op_t prev_a, prev_b;
   int  settle = 0;
   always @(negedge clk) begin
      if (mul_a == prev_a && mul_b == prev_b) begin
         if (settle < 100) settle <= settle + 1;
      end else begin
         settle <= 1;
      end
      prev_a <= mul_a;
      prev_b <= mul_b;
   end
   always_comb mul_c = (settle >= MUL_CYCLES) ? conv(mul_a, mul_b) : ~conv(mul_a, mul_b);

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic drive_req(int r, int av, int bv, bit expect_job);
      exp_t e;
      req_a[r]     = fill(av);
      req_b[r]     = fill(bv);
      req_valid[r] = 1'b1;
      if (expect_job) begin
         e.id = IDW'(r);
         e.c  = conv(fill(av), fill(bv));
         sb.push_back(e);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      req_valid = '0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== '0) $display("FAIL reset_req_ready got %b want 0", req_ready); else passed++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (resp_c !== '0) $display("FAIL reset_resp_c got %h want 0", resp_c); else passed++;
      checks++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL reset_mul_ab got %h / %h want 0", mul_a, mul_b); else passed++;
   endtask

   task automatic test_single_job();
      int   t_acc;
      bit   seen;
      exp_t e;
      sb.delete();
      @(posedge clk); #1;
      drive_req(2, 3, -2, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready[2] && req_valid[2]) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL single_accept timeout ready=%b", req_ready); else passed++;
      checks++; if (req_ready !== 4'b0100) $display("FAIL single_ready_onehot got %b want 0100", req_ready); else passed++;
      t_acc = cyc;
      @(posedge clk); #1 req_valid[2] = 1'b0;
      for (int c = 0; c < MUL_CYCLES; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0 || mul_a !== fill(3) || mul_b !== fill(-2))
            $display("FAIL single_wait cycle %0d got valid=%b busy=%b ready=%b want 0/1/0 with operands held", c, resp_valid, busy, req_ready);
         else passed++;
      end
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL single_resp timeout"); else passed++;
      checks++; if (cyc - t_acc !== MUL_CYCLES + 1) $display("FAIL single_latency got %0d want %0d", cyc - t_acc, MUL_CYCLES + 1); else passed++;
      if (sb.size() == 0) begin
         checks++; $display("FAIL single_sb got empty queue want one entry");
      end else begin
         e = sb.pop_front();
         checks++; if (resp_id !== e.id) $display("FAIL single_id got %0d want %0d", resp_id, e.id); else passed++;
         checks++; if (resp_c !== e.c) $display("FAIL single_c got %h want %h", resp_c, e.c); else passed++;
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL single_idle got busy=%b valid=%b want 0/0", busy, resp_valid); else passed++;
   endtask

   task automatic test_round_robin();
      int   order [5] = '{0, 1, 2, 3, 0};
      int   n_acc, n_resp, gid;
      exp_t e;
      apply_reset();
      sb.delete();
      for (int r = 0; r < NUM_REQ; r++) drive_req(r, r + 1, 5 - 3*r, 1'b0);
      for (int i = 0; i < 5; i++) begin
         e.id = IDW'(order[i]);
         e.c  = conv(fill(order[i] + 1), fill(5 - 3*order[i]));
         sb.push_back(e);
      end
      n_acc  = 0;
      n_resp = 0;
      for (int c = 0; c < 200 && n_resp < 5; c++) begin
         @(negedge clk);
         checks++; if ($countones(req_ready) > 1) $display("FAIL rr_onehot got %b want at most one bit", req_ready); else passed++;
         if (|(req_ready & req_valid)) begin
            gid = 0;
            for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) gid = r;
            checks++; if (n_acc >= 5 || gid !== order[n_acc]) $display("FAIL rr_grant #%0d got %0d want %0d", n_acc, gid, (n_acc < 5) ? order[n_acc] : -1); else passed++;
            n_acc++;
         end
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               checks++; $display("FAIL rr_sb got unexpected response id %0d want none", resp_id);
            end else begin
               e = sb.pop_front();
               checks++; if (resp_id !== e.id || resp_c !== e.c) $display("FAIL rr_resp #%0d got id %0d want %0d (data match %b)", n_resp, resp_id, e.id, resp_c === e.c); else passed++;
            end
            n_resp++;
         end
         @(posedge clk); #1;
         if (n_acc >= 5) req_valid = '0;
      end
      req_valid = '0;
      checks++; if (n_resp !== 5) $display("FAIL rr_count got %0d responses want 5", n_resp); else passed++;
   endtask

   task automatic test_backpressure();
      bit   seen;
      exp_t e;
      sb.delete();
      resp_ready = 1'b0;
      @(posedge clk); #1;
      drive_req(1, -5, 9, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready[1] && req_valid[1]) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL bp_accept timeout ready=%b", req_ready); else passed++;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      drive_req(3, 21, -8, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL bp_resp timeout"); else passed++;
      e.id = '0;
      e.c  = '0;
      if (sb.size() != 0) e = sb[0];
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_c !== e.c || req_ready !== '0)
            $display("FAIL bp_stall cycle %0d got valid=%b id=%0d ready=%b data_ok=%b want 1/1/0000/1", c + 1, resp_valid, resp_id, req_ready, resp_c === e.c);
         else passed++;
         @(posedge clk); #1;
      end
      req_valid[3] = 1'b0;
      resp_ready   = 1'b1;
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++; $display("FAIL bp_sb got empty queue want one entry");
      end else begin
         e = sb.pop_front();
         checks++; if (resp_valid !== 1'b1 || resp_id !== e.id || resp_c !== e.c) $display("FAIL bp_handshake got valid=%b id=%0d want 1/%0d", resp_valid, resp_id, e.id); else passed++;
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL bp_idle got busy=%b valid=%b want 0/0", busy, resp_valid); else passed++;
   endtask

   task automatic test_async_reset();
      bit   seen;
      int   gid;
      exp_t e;
      sb.delete();
      @(posedge clk); #1;
      drive_req(2, 7, -3, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready[2] && req_valid[2]) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL ar_accept timeout ready=%b", req_ready); else passed++;
      @(posedge clk); #1 req_valid[2] = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      checks++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL ar_mul_ab got %h / %h want 0", mul_a, mul_b); else passed++;
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) $display("FAIL ar_ctrl got valid=%b busy=%b ready=%b want 0/0/0", resp_valid, busy, req_ready); else passed++;
      checks++; if (resp_c !== '0 || resp_id !== '0) $display("FAIL ar_resp_regs got id=%0d c=%h want 0", resp_id, resp_c); else passed++;
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      checks++; if (seen) $display("FAIL ar_stale got resp_valid=1 want no response"); else passed++;
      @(posedge clk); #1;
      drive_req(1, 6, 6, 1'b1);
      drive_req(3, -9, 2, 1'b0);
      seen = 1'b0;
      gid  = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (|(req_ready & req_valid)) begin
            seen = 1'b1;
            for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) gid = r;
         end
      end
      checks++; if (gid !== 1) $display("FAIL ar_ptr_grant got %0d want 1", gid); else passed++;
      @(posedge clk); #1 req_valid = '0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      if (!seen || sb.size() == 0) begin
         checks++; $display("FAIL ar_resp got valid=%b queue=%0d want response", resp_valid, sb.size());
      end else begin
         e = sb.pop_front();
         checks++; if (resp_id !== e.id || resp_c !== e.c) $display("FAIL ar_resp got id %0d want %0d (data match %b)", resp_id, e.id, resp_c === e.c); else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int   acc_cyc [2];
      int   acc_id  [2];
      int   hs_cyc  [2];
      int   n_acc, n_resp;
      logic [NUM_REQ-1:0] drop;
      exp_t e;
      sb.delete();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      drive_req(0, 11, 13, 1'b1);
      drive_req(1, -17, 4, 1'b1);
      n_acc  = 0;
      n_resp = 0;
      for (int i = 0; i < 2; i++) begin
         acc_cyc[i] = 0;
         acc_id[i]  = -1;
         hs_cyc[i]  = 0;
      end
      for (int c = 0; c < 100 && n_resp < 2; c++) begin
         @(negedge clk);
         drop = req_ready & req_valid;
         if (|drop) begin
            if (n_acc < 2) begin
               acc_cyc[n_acc] = cyc;
               for (int r = 0; r < NUM_REQ; r++) if (drop[r]) acc_id[n_acc] = r;
            end
            n_acc++;
         end
         if (resp_valid && resp_ready) begin
            if (n_resp < 2) hs_cyc[n_resp] = cyc;
            if (sb.size() == 0) begin
               checks++; $display("FAIL b2b_sb got unexpected response id %0d want none", resp_id);
            end else begin
               e = sb.pop_front();
               checks++; if (resp_id !== e.id || resp_c !== e.c) $display("FAIL b2b_resp got id %0d want %0d (data match %b)", resp_id, e.id, resp_c === e.c); else passed++;
            end
            n_resp++;
         end
         @(posedge clk); #1;
         req_valid = req_valid & ~drop;
      end
      req_valid = '0;
      checks++; if (n_acc !== 2 || n_resp !== 2) $display("FAIL b2b_count got %0d accepts %0d responses want 2/2", n_acc, n_resp); else passed++;
      checks++; if (acc_id[0] !== 0 || acc_id[1] !== 1) $display("FAIL b2b_order got %0d,%0d want 0,1", acc_id[0], acc_id[1]); else passed++;
      checks++; if (acc_cyc[1] - acc_cyc[0] !== JOB_GAP) $display("FAIL b2b_gap got %0d want %0d", acc_cyc[1] - acc_cyc[0], JOB_GAP); else passed++;
      checks++; if (acc_cyc[1] - hs_cyc[0] !== NEXT_ACC_OFS) $display("FAIL b2b_overlap got %0d want %0d", acc_cyc[1] - hs_cyc[0], NEXT_ACC_OFS); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_round_robin();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
